// File: rtl/jtag_multichain_tap_if.sv
// ---------------------------------------------------------------------------
// jtag_multichain_tap_if
//   Bundle of the TAP pins, state decodes and user-chain fan-out for
//   jtag_multichain_tap. jtag_tck and tap_resetn are plain module ports and
//   are not part of this interface.
//
//   master : debugger / chain side (drives TMS, TDI, ir_status, chain_tdo)
//   slave  : the TAP controller (drives TDO, OE, state, decodes, chain_sel)
//
//   Signals
//     jtag_tms, jtag_tdi          test mode select / test data in
//     jtag_tdo, jtag_tdo_oe       test data out and its output enable
//     ir_status[IR_WIDTH-3:0]     status captured into IR[IR_WIDTH-1:2]
//     tap_state[3:0]              current controller state
//     tap_TestLogicReset ..
//     tap_UpdateDR                one-hot decodes of selected states
//     chain_sel[NUM_CHAINS-1:0]   one-hot active user chain
//     chain_tdi                   serial data towards the user chains
//     chain_tdo[NUM_CHAINS-1:0]   serial return of each user chain
// ---------------------------------------------------------------------------
interface jtag_multichain_tap_if #(
    parameter int IR_WIDTH   = 5,
    parameter int NUM_CHAINS = 4
);
    logic                    jtag_tms;
    logic                    jtag_tdi;
    logic                    jtag_tdo;
    logic                    jtag_tdo_oe;
    logic [IR_WIDTH-3:0]     ir_status;
    logic [3:0]              tap_state;
    logic                    tap_TestLogicReset;
    logic                    tap_CaptureDR;
    logic                    tap_ShiftDR;
    logic                    tap_PauseDR;
    logic                    tap_UpdateDR;
    logic [NUM_CHAINS-1:0]   chain_sel;
    logic                    chain_tdi;
    logic [NUM_CHAINS-1:0]   chain_tdo;

    modport master (
        output jtag_tms, jtag_tdi, ir_status, chain_tdo,
        input  jtag_tdo, jtag_tdo_oe, tap_state, tap_TestLogicReset,
               tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR,
               chain_sel, chain_tdi
    );

    modport slave (
        input  jtag_tms, jtag_tdi, ir_status, chain_tdo,
        output jtag_tdo, jtag_tdo_oe, tap_state, tap_TestLogicReset,
               tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR,
               chain_sel, chain_tdi
    );
endinterface

// File: rtl/jtag_multichain_tap.sv
// ---------------------------------------------------------------------------
// jtag_multichain_tap
//   IEEE 1149.1 TAP controller with IDCODE, optional USERCODE, BYPASS and
//   NUM_CHAINS user debug chains selected by opcodes CHAIN_BASE+k.
//   No boundary scan: EXTEST / SAMPLE_PRELOAD and unknown opcodes act as
//   BYPASS.
//
//   Ports
//     jtag_tck    test clock (state and shift registers on rising edge,
//                 instruction, chain_sel and TDO on falling edge)
//     tap_resetn  asynchronous active-low reset (TRSTn + power-on)
//     bus         jtag_multichain_tap_if.slave (pins, decodes, chains)
//
//   Configuration macro
//     JTAG_TAP_USERCODE_EN  implements the USERCODE register (opcode 6);
//                           when undefined opcode 6 decodes as BYPASS.
// ---------------------------------------------------------------------------
module jtag_multichain_tap #(
    parameter int          IR_WIDTH      = 5,
    parameter int          NUM_CHAINS    = 4,
    parameter int          CHAIN_BASE    = 8,
    parameter logic [31:0] JTAG_IDCODE   = 32'h000009DD,
    parameter logic [31:0] JTAG_USERCODE = 32'h0
) (
    input  logic                 jtag_tck,
    input  logic                 tap_resetn,
    jtag_multichain_tap_if.slave bus
);

    typedef enum logic [3:0] {
        TLR   = 4'h0, RTI   = 4'h1, SELDR = 4'h2, CAPDR = 4'h3,
        SHDR  = 4'h4, EX1DR = 4'h5, PSDR  = 4'h6, EX2DR = 4'h7,
        UPDDR = 4'h8, SELIR = 4'h9, CAPIR = 4'hA, SHIR  = 4'hB,
        EX1IR = 4'hC, PSIR  = 4'hD, EX2IR = 4'hE, UPDIR = 4'hF
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] OP_IDCODE   = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] OP_USERCODE = IR_WIDTH'(6);

    tap_state_e               state_reg, state_next;
    logic [IR_WIDTH-1:0]      ir_shift_reg;
    logic [IR_WIDTH-1:0]      ir_reg, ir_next;
    logic [NUM_CHAINS-1:0]    chain_sel_reg, chain_hit;
    logic                     bypass_reg;
    logic [31:0]              idcode_reg;
    logic                     tdo_reg, tdo_oe_reg;
    logic                     sel_idcode, sel_usercode, sel_chain, sel_bypass;
    logic                     dr_tdo;

    // ---------------- controller FSM ----------------
    always_ff @(posedge jtag_tck or negedge tap_resetn) begin
        if (!tap_resetn) state_reg <= TLR;
        else             state_reg <= state_next;
    end

    always_comb begin
        state_next = TLR;
        case (state_reg)
            TLR:   state_next = bus.jtag_tms ? TLR   : RTI;
            RTI:   state_next = bus.jtag_tms ? SELDR : RTI;
            SELDR: state_next = bus.jtag_tms ? SELIR : CAPDR;
            CAPDR: state_next = bus.jtag_tms ? EX1DR : SHDR;
            SHDR:  state_next = bus.jtag_tms ? EX1DR : SHDR;
            EX1DR: state_next = bus.jtag_tms ? UPDDR : PSDR;
            PSDR:  state_next = bus.jtag_tms ? EX2DR : PSDR;
            EX2DR: state_next = bus.jtag_tms ? UPDDR : SHDR;
            UPDDR: state_next = bus.jtag_tms ? SELDR : RTI;
            SELIR: state_next = bus.jtag_tms ? TLR   : CAPIR;
            CAPIR: state_next = bus.jtag_tms ? EX1IR : SHIR;
            SHIR:  state_next = bus.jtag_tms ? EX1IR : SHIR;
            EX1IR: state_next = bus.jtag_tms ? UPDIR : PSIR;
            PSIR:  state_next = bus.jtag_tms ? EX2IR : PSIR;
            EX2IR: state_next = bus.jtag_tms ? UPDIR : SHIR;
            UPDIR: state_next = bus.jtag_tms ? SELDR : RTI;
            default: state_next = TLR;
        endcase
    end

    assign bus.tap_state          = state_reg;
    assign bus.tap_TestLogicReset = (state_reg == TLR);
    assign bus.tap_CaptureDR      = (state_reg == CAPDR);
    assign bus.tap_ShiftDR        = (state_reg == SHDR);
    assign bus.tap_PauseDR        = (state_reg == PSDR);
    assign bus.tap_UpdateDR       = (state_reg == UPDDR);

    // ---------------- instruction path ----------------
    always_ff @(posedge jtag_tck or negedge tap_resetn) begin
        if (!tap_resetn) begin
            ir_shift_reg <= '0;
        end else if (state_reg == CAPIR) begin
            ir_shift_reg <= {bus.ir_status, 2'b01};
        end else if (state_reg == SHIR) begin
            ir_shift_reg <= {bus.jtag_tdi, ir_shift_reg[IR_WIDTH-1:1]};
        end
    end

    always_comb begin
        ir_next = ir_reg;
        if (state_reg == UPDIR)    ir_next = ir_shift_reg;
        else if (state_reg == TLR) ir_next = OP_IDCODE;
    end

    // chain_sel is decoded from the next instruction so it is registered on
    // the same falling edge as the instruction itself.
    for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_chain_dec
        assign chain_hit[gi] = (ir_next == IR_WIDTH'(CHAIN_BASE + gi));
    end

    always_ff @(negedge jtag_tck or negedge tap_resetn) begin
        if (!tap_resetn) begin
            ir_reg        <= OP_IDCODE;
            chain_sel_reg <= '0;
        end else begin
            ir_reg        <= ir_next;
            chain_sel_reg <= chain_hit;
        end
    end

    assign bus.chain_sel = chain_sel_reg;
    assign bus.chain_tdi = bus.jtag_tdi;

    assign sel_chain  = |chain_sel_reg;
    assign sel_idcode = (ir_reg == OP_IDCODE);
    assign sel_bypass = !sel_chain && !sel_idcode && !sel_usercode;

    // ---------------- data registers ----------------
    always_ff @(posedge jtag_tck or negedge tap_resetn) begin
        if (!tap_resetn) begin
            bypass_reg <= 1'b0;
        end else if (sel_bypass) begin
            if (state_reg == CAPDR)     bypass_reg <= 1'b0;
            else if (state_reg == SHDR) bypass_reg <= bus.jtag_tdi;
        end
    end

    always_ff @(posedge jtag_tck or negedge tap_resetn) begin
        if (!tap_resetn) begin
            idcode_reg <= JTAG_IDCODE;
        end else if (sel_idcode) begin
            if (state_reg == CAPDR)     idcode_reg <= JTAG_IDCODE;
            else if (state_reg == SHDR) idcode_reg <= {bus.jtag_tdi, idcode_reg[31:1]};
        end
    end

`ifdef JTAG_TAP_USERCODE_EN
    logic [31:0] usercode_reg;

    assign sel_usercode = (ir_reg == OP_USERCODE);

    always_ff @(posedge jtag_tck or negedge tap_resetn) begin
        if (!tap_resetn) begin
            usercode_reg <= JTAG_USERCODE;
        end else if (sel_usercode) begin
            if (state_reg == CAPDR)     usercode_reg <= JTAG_USERCODE;
            else if (state_reg == SHDR) usercode_reg <= {bus.jtag_tdi, usercode_reg[31:1]};
        end
    end
`else
    logic unused_usercode;

    assign sel_usercode    = 1'b0;
    assign unused_usercode = ^{JTAG_USERCODE, OP_USERCODE};
`endif

    // chain_sel is one-hot, so masking and OR-reducing picks the active chain.
    always_comb begin
        dr_tdo = bypass_reg;
        if (sel_chain)       dr_tdo = |(chain_sel_reg & bus.chain_tdo);
        else if (sel_idcode) dr_tdo = idcode_reg[0];
`ifdef JTAG_TAP_USERCODE_EN
        else if (sel_usercode) dr_tdo = usercode_reg[0];
`endif
    end

    // ---------------- TDO driver ----------------
    always_ff @(negedge jtag_tck or negedge tap_resetn) begin
        if (!tap_resetn) begin
            tdo_reg    <= 1'b0;
            tdo_oe_reg <= 1'b0;
        end else begin
            tdo_oe_reg <= (state_reg == SHIR) || (state_reg == SHDR);
            if (state_reg == SHIR)      tdo_reg <= ir_shift_reg[0];
            else if (state_reg == SHDR) tdo_reg <= dr_tdo;
        end
    end

    assign bus.jtag_tdo    = tdo_reg;
    assign bus.jtag_tdo_oe = tdo_oe_reg;

endmodule

// File: tb/tb_jtag_multichain_tap.sv
// ---------------------------------------------------------------------------
// tb_jtag_multichain_tap
//   Directed bench for jtag_multichain_tap with default parameters: FSM walk
//   and TMS reset, IDCODE scan, IR capture, chain routing, BYPASS delay,
//   unused opcodes and asynchronous reset in the middle of a chain scan.
// ---------------------------------------------------------------------------
module tb_jtag_multichain_tap;

    localparam int IRW = 5;
    localparam int NCH = 4;

    logic jtag_tck   = 1'b0;
    logic tap_resetn = 1'b0;
    int   checks     = 0;
    int   failures   = 0;

    jtag_multichain_tap_if #(.IR_WIDTH(IRW), .NUM_CHAINS(NCH)) bus ();

    jtag_multichain_tap #(.IR_WIDTH(IRW), .NUM_CHAINS(NCH)) dut (
        .jtag_tck   (jtag_tck),
        .tap_resetn (tap_resetn),
        .bus        (bus)
    );

    always #10 jtag_tck = ~jtag_tck;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s value=%0h", tag, got);
        end
    endtask

    // One TCK period: inputs set after the falling edge, outputs observed
    // 1 ns after the next falling edge.
    task automatic step(input logic tms, input logic tdi);
        bus.jtag_tms = tms;
        bus.jtag_tdi = tdi;
        @(posedge jtag_tck);
        @(negedge jtag_tck);
        #1;
    endtask

    // RTI -> IR scan of op -> RTI; returns the captured IR bits, LSB first.
    task automatic ir_scan(input logic [IRW-1:0] op, output logic [IRW-1:0] cap);
        cap = '0;
        step(1'b1, 1'b0);               // SelDR
        step(1'b1, 1'b0);               // SelIR
        step(1'b0, 1'b0);               // CapIR
        step(1'b0, 1'b0);               // ShIR, first bit on TDO
        cap[0] = bus.jtag_tdo;
        for (int i = 0; i < IRW; i++) begin
            step(i == IRW - 1, op[i]);
            if (i < IRW - 1) cap[i+1] = bus.jtag_tdo;
        end
        step(1'b1, 1'b0);               // UpdIR
        step(1'b0, 1'b0);               // RTI
    endtask

    // RTI -> n-bit DR scan -> RTI. Chain cmask returns cpat bit by bit; the
    // other chains return the inverse so a wrong selection shows up.
    task automatic dr_scan(input int n, input logic [63:0] din, input logic [63:0] cpat,
                           input logic [NCH-1:0] cmask, output logic [63:0] dout);
        dout = '0;
        step(1'b1, 1'b0);               // SelDR
        step(1'b0, 1'b0);               // CapDR
        chk("oe_capture_dr", 64'(bus.jtag_tdo_oe), 64'h0);
        bus.chain_tdo = cpat[0] ? cmask : ~cmask;
        step(1'b0, 1'b0);               // ShDR
        dout[0] = bus.jtag_tdo;
        chk("oe_shift_dr", 64'(bus.jtag_tdo_oe), 64'h1);
        for (int i = 0; i < n; i++) begin
            if (i < n - 1) bus.chain_tdo = cpat[i+1] ? cmask : ~cmask;
            step(i == n - 1, din[i]);
            if (i < n - 1) dout[i+1] = bus.jtag_tdo;
        end
        chk("oe_exit1_dr", 64'(bus.jtag_tdo_oe), 64'h0);
        step(1'b1, 1'b0);               // UpdDR
        step(1'b0, 1'b0);               // RTI
    endtask

    logic [IRW-1:0] cap;
    logic [63:0]    d;

    initial begin
        bus.jtag_tms  = 1'b1;
        bus.jtag_tdi  = 1'b1;
        bus.ir_status = 3'b101;
        bus.chain_tdo = '0;

        // ---- reset state ----
        #25;
        chk("rst_state",     64'(bus.tap_state), 64'h0);
        chk("rst_tlr",       64'(bus.tap_TestLogicReset), 64'h1);
        chk("rst_capdr",     64'(bus.tap_CaptureDR), 64'h0);
        chk("rst_shdr",      64'(bus.tap_ShiftDR), 64'h0);
        chk("rst_chain_sel", 64'(bus.chain_sel), 64'h0);
        chk("rst_tdo",       64'(bus.jtag_tdo), 64'h0);
        chk("rst_oe",        64'(bus.jtag_tdo_oe), 64'h0);
        chk("chain_tdi",     64'(bus.chain_tdi), 64'h1);
        @(negedge jtag_tck);
        #1;
        tap_resetn = 1'b1;

        // ---- FSM walk and five-TMS reset from Pause-DR ----
        step(1'b0, 1'b0);
        chk("st_rti", 64'(bus.tap_state), 64'h1);
        step(1'b1, 1'b0);
        chk("st_seldr", 64'(bus.tap_state), 64'h2);
        step(1'b0, 1'b0);
        chk("st_capdr", 64'(bus.tap_state), 64'h3);
        chk("dec_capdr", 64'(bus.tap_CaptureDR), 64'h1);
        step(1'b0, 1'b0);
        chk("dec_shdr", 64'(bus.tap_ShiftDR), 64'h1);
        step(1'b1, 1'b0);
        chk("st_ex1dr", 64'(bus.tap_state), 64'h5);
        step(1'b0, 1'b0);
        chk("st_psdr", 64'(bus.tap_state), 64'h6);
        chk("dec_psdr", 64'(bus.tap_PauseDR), 64'h1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("tms5_state", 64'(bus.tap_state), 64'h0);
        chk("tms5_tlr", 64'(bus.tap_TestLogicReset), 64'h1);
        step(1'b0, 1'b0);               // RTI

        // ---- IDCODE after reset ----
        dr_scan(32, 64'h0, 64'h0, '0, d);
        chk("idcode", 64'(d[31:0]), 64'h9DD);

        // ---- IR capture and chain 2 ----
        ir_scan(5'h0A, cap);
        chk("ir_capture", 64'(cap), 64'h15);
        chk("chain_sel_c2", 64'(bus.chain_sel), 64'h4);
        dr_scan(8, 64'h0, 64'h96, 4'b0100, d);
        chk("chain2_96", 64'(d[7:0]), 64'h96);
        dr_scan(8, 64'hFF, 64'h3C, 4'b0100, d);
        chk("chain2_3c", 64'(d[7:0]), 64'h3C);

        // ---- BYPASS: one TCK of delay ----
        ir_scan(5'h1F, cap);
        chk("chain_sel_byp", 64'(bus.chain_sel), 64'h0);
        dr_scan(9, 64'h0A5, 64'h0, '0, d);
        chk("bypass_a5", 64'(d[8:0]), 64'h14A);

        // ---- opcode 6 ----
        ir_scan(5'h06, cap);
        dr_scan(9, 64'h0A5, 64'h0, '0, d);
`ifdef JTAG_TAP_USERCODE_EN
        chk("usercode", 64'(d[8:0]), 64'h0);
`else
        chk("op6_bypass", 64'(d[8:0]), 64'h14A);
`endif

        // ---- EXTEST acts as BYPASS ----
        ir_scan(5'h00, cap);
        chk("chain_sel_extest", 64'(bus.chain_sel), 64'h0);
        dr_scan(9, 64'h05A, 64'h0, '0, d);
        chk("extest_bypass", 64'(d[8:0]), 64'h0B4);

        // ---- asynchronous reset mid Shift-DR on chain 1 ----
        ir_scan(5'h09, cap);
        chk("chain_sel_c1", 64'(bus.chain_sel), 64'h2);
        step(1'b1, 1'b0);               // SelDR
        step(1'b0, 1'b0);               // CapDR
        bus.chain_tdo = 4'b0010;
        step(1'b0, 1'b0);               // ShDR
        chk("c1_tdo", 64'(bus.jtag_tdo), 64'h1);
        chk("c1_oe", 64'(bus.jtag_tdo_oe), 64'h1);
        step(1'b0, 1'b1);
        #5;
        tap_resetn = 1'b0;
        #1;
        chk("arst_state", 64'(bus.tap_state), 64'h0);
        chk("arst_chain_sel", 64'(bus.chain_sel), 64'h0);
        chk("arst_tdo", 64'(bus.jtag_tdo), 64'h0);
        chk("arst_oe", 64'(bus.jtag_tdo_oe), 64'h0);
        @(negedge jtag_tck);
        #1;
        tap_resetn    = 1'b1;
        bus.chain_tdo = '0;
        step(1'b0, 1'b0);               // RTI
        dr_scan(32, 64'h0, 64'h0, '0, d);
        chk("idcode_after_arst", 64'(d[31:0]), 64'h9DD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtag_multichain_tap.md
JTAG_MULTICHAIN_TAP -- requirements
Module: jtag_multichain_tap

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 5, instruction register width; legal range 4..8.
REQ-002 SHALL have parameter NUM_CHAINS, default 4, number of user debug chains; legal range 1..8.
REQ-003 SHALL have parameter CHAIN_BASE, default 8, opcode of chain 0; chain k uses CHAIN_BASE+k, and CHAIN_BASE+NUM_CHAINS-1 < 2^IR_WIDTH-1.
REQ-004 SHALL have parameter JTAG_IDCODE, default 32'h000009DD, IDCODE capture value; bit 0 is 1.
REQ-005 SHALL have parameter JTAG_USERCODE, default 32'h0, USERCODE capture value.
REQ-006 jtag_tck  input  1  test clock.
REQ-007 tap_resetn  input  1  reset, asynchronous, active-low (TRSTn combined with power-on reset).
REQ-008 jtag_tms  input  1  test mode select.
REQ-009 jtag_tdi  input  1  test data in.
REQ-010 jtag_tdo  output  1  test data out, registered on falling TCK.
REQ-011 jtag_tdo_oe  output  1  TDO output enable, registered on falling TCK.
REQ-012 ir_status  input  IR_WIDTH-2  status captured into IR[IR_WIDTH-1:2] in Capture-IR.
REQ-013 tap_state  output  4  current controller state.
REQ-014 tap_TestLogicReset, tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR  output  1 each  state decodes.
REQ-015 chain_sel  output  NUM_CHAINS  one-hot selection of the active user chain; all zero when no chain instruction is active.
REQ-016 chain_tdi  output  1  equals jtag_tdi.
REQ-017 chain_tdo  input  NUM_CHAINS  serial return of each user chain.

Function
REQ-018 The FSM SHALL implement all 16 IEEE 1149.1 states with encoding TLR=0, RTI=1, SelDR=2, CapDR=3, ShDR=4, Ex1DR=5, PsDR=6, Ex2DR=7, UpdDR=8, SelIR=9, CapIR=A, ShIR=B, Ex1IR=C, PsIR=D, Ex2IR=E, UpdIR=F, and SHALL update on rising TCK per the standard TMS transitions.
REQ-019 An undefined state SHALL cause a transition to TestLogicReset on the next rising TCK.
REQ-020 Five consecutive rising TCK edges with TMS=1 SHALL reach TestLogicReset from any state.
REQ-021 The tap_* decode outputs SHALL be high exactly while tap_state equals the corresponding state.
REQ-022 In Capture-IR the IR shift register SHALL load {ir_status, 2'b01}; in Shift-IR it SHALL shift right with jtag_tdi entering the MSB.
REQ-023 The instruction register SHALL load the IR shift register on falling TCK in Update-IR, and SHALL load IDCODE on falling TCK in TestLogicReset.
REQ-024 Opcodes SHALL be: EXTEST=0, SAMPLE_PRELOAD=1, IDCODE=2, USERCODE=6, CHAIN k=CHAIN_BASE+k, BYPASS=all ones; every other opcode SHALL select BYPASS.
REQ-025 EXTEST and SAMPLE_PRELOAD SHALL select BYPASS behaviour, since there is no boundary scan.
REQ-026 chain_sel[k] SHALL be 1 if and only if the instruction equals CHAIN_BASE+k, and SHALL change only on falling TCK.
REQ-027 The BYPASS register SHALL load 0 in Capture-DR and shift jtag_tdi in Shift-DR when selected.
REQ-028 The IDCODE and USERCODE registers SHALL load their parameter in Capture-DR and shift right, jtag_tdi entering bit 31, in Shift-DR when selected.
REQ-029 On falling TCK, jtag_tdo SHALL take IR bit 0 in Shift-IR, the selected DR bit 0 (or chain_tdo[k]) in Shift-DR, and hold its value otherwise.
REQ-030 jtag_tdo_oe SHALL equal (state==ShIR or state==ShDR), sampled on falling TCK.
REQ-031 The first TDO bit of a scan SHALL appear on the falling edge after the Capture-to-Shift rising edge; an N-bit register SHALL shift out completely in N Shift cycles.

Reset
REQ-032 Assertion of tap_resetn SHALL immediately force tap_state=TLR, tap_TestLogicReset=1, all other tap_* outputs 0, instruction=IDCODE, chain_sel=0, IR shift register=0, bypass=0, idcode=JTAG_IDCODE and usercode=JTAG_USERCODE.
REQ-033 Assertion of tap_resetn SHALL also force jtag_tdo=0 and jtag_tdo_oe=0.
REQ-034 Reset asserted mid-scan SHALL abort the scan without an Update; release SHALL be synchronised by the first rising TCK.

Configuration
REQ-035 With macro JTAG_TAP_USERCODE_EN defined, the USERCODE register and opcode SHALL be implemented; without it, opcode 6 SHALL decode as BYPASS and no USERCODE flops SHALL exist.

Verification
REQ-036 Start in any state, apply TMS=1 for 5 TCKs -> tap_state=0 and tap_TestLogicReset=1.
REQ-037 After reset, apply a 32-bit DR scan with TDI=0 -> TDO LSB-first returns 32'h000009DD, and jtag_tdo_oe=1 only during Shift-DR.
REQ-038 With IR_WIDTH=5 and ir_status=3'b101, apply an IR scan -> TDO bits 1,0,1,0,1 (LSB first).
REQ-039 Load opcode 5'h0A -> chain_sel=4'b0100 after the falling edge in Update-IR, and TDO in Shift-DR tracks chain_tdo[2] with a half-cycle delay.
REQ-040 Load BYPASS and shift 8'hA5 -> the same pattern emerges delayed by 1 TCK; with JTAG_TAP_USERCODE_EN undefined, opcode 6 behaves identically.
REQ-041 Pulse tap_resetn low mid Shift-DR with chain 1 selected -> chain_sel=0, instruction=IDCODE, TDO=0 and OE=0 without waiting for TCK.
